// File: rtl/vga_pkg.sv
// Shared VGA definitions: default screen geometry, RRRGGGBB field layout,
// named colours and the per-axis state types used by pixel sources.
package vga_pkg;

  localparam int unsigned DefScreenW = 640;
  localparam int unsigned DefScreenH = 480;

  // Coordinates are 10 bits; geometry math gets one extra bit of headroom.
  localparam int unsigned CoordW = 10;
  localparam int unsigned MathW  = 11;

  // RRRGGGBB field positions.
  localparam int unsigned RedMsb = 7;
  localparam int unsigned RedLsb = 5;
  localparam int unsigned GrnMsb = 4;
  localparam int unsigned GrnLsb = 2;
  localparam int unsigned BluMsb = 1;
  localparam int unsigned BluLsb = 0;

  function automatic logic [7:0] rgb(input logic [2:0] r, input logic [2:0] g,
                                     input logic [1:0] b);
    logic [7:0] c;
    c                = '0;
    c[RedMsb:RedLsb] = r;
    c[GrnMsb:GrnLsb] = g;
    c[BluMsb:BluLsb] = b;
    return c;
  endfunction

  localparam logic [7:0] ColorBlack = rgb(3'b000, 3'b000, 2'b00);
  localparam logic [7:0] ColorWhite = rgb(3'b111, 3'b111, 2'b11);
  localparam logic [7:0] ColorRed   = rgb(3'b111, 3'b000, 2'b00);
  localparam logic [7:0] ColorBlue  = rgb(3'b000, 3'b000, 2'b11);

  typedef enum logic {
    DirPos = 1'b0,
    DirNeg = 1'b1
  } dir_e;

  // Result of advancing one axis by one frame.
  typedef struct packed {
    logic [CoordW-1:0] pos;
    dir_e              dir;
    logic              flip;
  } axis_t;

endpackage

// File: rtl/edge_detect.sv
// Registered falling-edge detector.
//   clk_i        : clock
//   rst_n        : asynchronous active-low reset
//   sig_i        : monitored level (e.g. hsync/vsync)
//   fall_o       : combinational fall indication (sig_q & ~sig_i)
//   fall_pulse_o : fall_o delayed one cycle, one-cycle pulse
module edge_detect (
  input  logic clk_i,
  input  logic rst_n,
  input  logic sig_i,
  output logic fall_o,
  output logic fall_pulse_o
);

  logic sig_q;
  logic pulse_q;

  // sig_q resets low so a level held high through reset is not seen as a fall.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sig_q   <= sig_i;
      pulse_q <= fall_o;
    end
  end

  assign fall_o       = sig_q & ~sig_i;
  assign fall_pulse_o = pulse_q;

endmodule

// File: rtl/bouncing_box_gen.sv
// Animated pixel source: a solid box bouncing off the screen edges over a
// background with a 1-pixel border. Position changes only on the vsync falling
// edge, so a frame never shows a half-moved box.
//   clk_i        : pixel clock
//   rst_n        : asynchronous active-low reset
//   enable_i     : 1 = animate, 0 = hold position
//   vsync_i      : driver vsync, active high
//   x_i, y_i     : current pixel coordinate
//   color_o      : RRRGGGBB colour for the previous cycle's (x,y)
//   frame_tick_o : one-cycle pulse per vsync falling edge
//   bounce_o     : one-cycle pulse on a frame where any direction flipped
module bouncing_box_gen
  import vga_pkg::*;
#(
  parameter int unsigned SCREEN_W     = DefScreenW,
  parameter int unsigned SCREEN_H     = DefScreenH,
  parameter int unsigned BOX_SIZE     = 32,
  parameter int unsigned STEP         = 2,
  parameter int unsigned INIT_X       = 0,
  parameter int unsigned INIT_Y       = 0,
  parameter logic [7:0]  BOX_COLOR    = ColorRed,
  parameter logic [7:0]  BORDER_COLOR = ColorWhite,
  parameter logic [7:0]  BG_COLOR     = ColorBlue
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              vsync_i,
  input  logic [CoordW-1:0] x_i,
  input  logic [CoordW-1:0] y_i,
  output logic [7:0]        color_o,
  output logic              frame_tick_o,
  output logic              bounce_o
);

  localparam logic [MathW-1:0]  LimX  = MathW'(SCREEN_W - BOX_SIZE);
  localparam logic [MathW-1:0]  LimY  = MathW'(SCREEN_H - BOX_SIZE);
  localparam logic [MathW-1:0]  StepW = MathW'(STEP);
  localparam logic [MathW-1:0]  BoxW  = MathW'(BOX_SIZE);
  localparam logic [MathW-1:0]  LastX = MathW'(SCREEN_W - 1);
  localparam logic [MathW-1:0]  LastY = MathW'(SCREEN_H - 1);
  localparam logic [CoordW-1:0] InitX = CoordW'(INIT_X);
  localparam logic [CoordW-1:0] InitY = CoordW'(INIT_Y);

  // One frame of motion on one axis; edges clamp exactly onto 0 or lim.
  function automatic axis_t step_axis(input logic [CoordW-1:0] pos, input dir_e dir,
                                      input logic [MathW-1:0] lim,
                                      input logic [MathW-1:0] step);
    axis_t            r;
    logic [MathW-1:0] pos_w;
    logic [MathW-1:0] inc;
    logic [MathW-1:0] dec;
    pos_w  = {1'b0, pos};
    inc    = pos_w + step;
    dec    = pos_w - step;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (dir == DirPos) begin
      if (inc >= lim) begin
        r.pos  = lim[CoordW-1:0];
        r.dir  = DirNeg;
        r.flip = 1'b1;
      end else begin
        r.pos = inc[CoordW-1:0];
      end
    end else begin
      if (pos_w <= step) begin
        r.pos  = '0;
        r.dir  = DirPos;
        r.flip = 1'b1;
      end else begin
        r.pos = dec[CoordW-1:0];
      end
    end
    return r;
  endfunction

  logic              vsync_fall;
  logic [CoordW-1:0] box_x_q, box_x_d;
  logic [CoordW-1:0] box_y_q, box_y_d;
  dir_e              dir_x_q, dir_x_d;
  dir_e              dir_y_q, dir_y_d;
  logic              bounce_q, bounce_d;
  logic [7:0]        color_q, color_d;
  axis_t             nxt_x, nxt_y;
  logic              upd;

  edge_detect u_vsync_edge (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .sig_i        (vsync_i),
    .fall_o       (vsync_fall),
    .fall_pulse_o (frame_tick_o)
  );

  always_comb begin
    nxt_x    = step_axis(box_x_q, dir_x_q, LimX, StepW);
    nxt_y    = step_axis(box_y_q, dir_y_q, LimY, StepW);
    upd      = vsync_fall & enable_i;
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = upd & (nxt_x.flip | nxt_y.flip);
    if (upd) begin
      box_x_d = nxt_x.pos;
      box_y_d = nxt_y.pos;
      dir_x_d = nxt_x.dir;
      dir_y_d = nxt_y.dir;
    end
  end

  logic [MathW-1:0] xw, yw, bx, by;
  logic             in_box, on_border;

  always_comb begin
    xw        = {1'b0, x_i};
    yw        = {1'b0, y_i};
    bx        = {1'b0, box_x_q};
    by        = {1'b0, box_y_q};
    in_box    = (xw >= bx) && (xw < bx + BoxW) && (yw >= by) && (yw < by + BoxW);
    on_border = (x_i == '0) || (xw == LastX) || (y_i == '0) || (yw == LastY);
    if (in_box) begin
      color_d = BOX_COLOR;
    end else if (on_border) begin
      color_d = BORDER_COLOR;
    end else begin
      color_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      box_x_q  <= InitX;
      box_y_q  <= InitY;
      dir_x_q  <= DirPos;
      dir_y_q  <= DirPos;
      bounce_q <= 1'b0;
      color_q  <= ColorBlack;
    end else begin
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      bounce_q <= bounce_d;
      color_q  <= color_d;
    end
  end

  assign color_o  = color_q;
  assign bounce_o = bounce_q;

endmodule
